pipe_if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline, sitting directly upstream of the ID-stage control unit. It holds the PC and selects the next PC from the control unit's `pcsource` and `wpcir` outputs. It drives the instruction-memory address and latches `{pc+4, instruction}` into the IF/ID register for decode. It also keeps a saturating count of load-use stall cycles for performance measurement.

---
 rtl/pipe_if_stage.sv | 74 +++++++
 tb/tb_pipe_if_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID register and saturating load-use stall counter.
// Optional macro IF_FLUSH_EN: squash the delay-slot instruction on a taken branch/jump.
module pipe_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       pcsource,
   input  logic             wpcir,
   input  logic [31:0]      bpc,
   input  logic [31:0]      rpc,
   input  logic [31:0]      jpc,
   input  logic [31:0]      imem_ins,
   output logic [31:0]      imem_addr,
   output logic [31:0]      pc,
   output logic [31:0]      dpc4,
   output logic [31:0]      dinst,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [31:0]      r_pc;
   logic [31:0]      r_dpc4;
   logic [31:0]      r_dinst;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [31:0]      w_pc4;
   logic [31:0]      w_npc;
   logic [31:0]      w_sel;
   logic [31:0]      w_next_inst;

   assign w_pc4 = r_pc + 32'd4;

   always_comb begin
      w_sel = w_pc4;
      unique case (pcsource)
         2'b00: w_sel = w_pc4;
         2'b01: w_sel = bpc;
         2'b10: w_sel = rpc;
         2'b11: w_sel = jpc;
         default: w_sel = w_pc4;
      endcase
      // word-align every target so pc[1:0] stays 00
      w_npc = {w_sel[31:2], 2'b00};
   end

`ifdef IF_FLUSH_EN
   assign w_next_inst = (pcsource != 2'b00) ? '0 : imem_ins;
`else
   assign w_next_inst = imem_ins;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_dpc4      <= '0;
         r_dinst     <= '0;
         r_stall_cnt <= '0;
      end else if (wpcir) begin
         r_pc    <= w_npc;
         r_dpc4  <= w_pc4;
         r_dinst <= w_next_inst;
      end else if (r_stall_cnt != '1) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign dpc4      = r_dpc4;
   assign dinst     = r_dinst;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed scoreboard bench for pipe_if_stage; a second instance with a 4-bit counter checks saturation.
module tb_pipe_if_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  pcsource;
   logic        wpcir;
   logic [31:0] bpc, rpc, jpc;
   logic [31:0] imem_ins, imem_addr, pc, dpc4, dinst;
   logic [31:0] stall_cnt;
   logic [31:0] imem_ins_s, imem_addr_s, pc_s, dpc4_s, dinst_s;
   logic [3:0]  stall_cnt_s;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] dpc4;
      logic [31:0] dinst;
      logic [31:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t        sb[$];
   exp_t        m;

   always #5 clock = ~clock;

   assign imem_ins   = imem_addr ^ 32'hA5A5_A5A5;
   assign imem_ins_s = imem_addr_s ^ 32'hA5A5_A5A5;

   pipe_if_stage u_dut (
      .clock(clock), .reset(reset), .pcsource(pcsource), .wpcir(wpcir),
      .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_ins(imem_ins),
      .imem_addr(imem_addr), .pc(pc), .dpc4(dpc4), .dinst(dinst),
      .stall_cnt(stall_cnt)
   );

   pipe_if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_sat (
      .clock(clock), .reset(reset), .pcsource(pcsource), .wpcir(wpcir),
      .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_ins(imem_ins_s),
      .imem_addr(imem_addr_s), .pc(pc_s), .dpc4(dpc4_s), .dinst(dinst_s),
      .stall_cnt(stall_cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, push the model's expected post-edge state, then compare.
   task automatic step(input logic rst, input logic [1:0] ps, input logic wp,
                       input logic [31:0] b, input logic [31:0] r, input logic [31:0] j);
      exp_t e;
      logic [31:0] sel;
      reset = rst; pcsource = ps; wpcir = wp; bpc = b; rpc = r; jpc = j;
      e = m;
      if (rst) begin
         e.pc = 32'h0; e.dpc4 = 32'h0; e.dinst = 32'h0; e.cnt = 32'h0; e.cnt4 = 4'h0;
      end else if (wp) begin
         case (ps)
            2'b00: sel = m.pc + 32'd4;
            2'b01: sel = b;
            2'b10: sel = r;
            default: sel = j;
         endcase
         e.pc   = sel & 32'hFFFF_FFFC;
         e.dpc4 = m.pc + 32'd4;
`ifdef IF_FLUSH_EN
         e.dinst = (ps != 2'b00) ? 32'h0 : (m.pc ^ 32'hA5A5_A5A5);
`else
         e.dinst = m.pc ^ 32'hA5A5_A5A5;
`endif
      end else begin
         if (m.cnt != 32'hFFFF_FFFF) e.cnt = m.cnt + 32'd1;
         if (m.cnt4 != 4'hF) e.cnt4 = m.cnt4 + 4'd1;
      end
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      chk("dpc4", dpc4, e.dpc4);
      chk("dinst", dinst, e.dinst);
      chk("stall_cnt", stall_cnt, e.cnt);
      chk("stall_cnt_w4", {28'h0, stall_cnt_s}, {28'h0, e.cnt4});
      m = e;
   endtask

   initial begin
      m = '{pc: 32'h0, dpc4: 32'h0, dinst: 32'h0, cnt: 32'h0, cnt4: 4'h0};
      reset = 1'b1; pcsource = 2'b00; wpcir = 1'b1;
      bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
      @(negedge clock);

      step(1, 2'b00, 1, 0, 0, 0);
      step(1, 2'b00, 1, 0, 0, 0);
      chk("reset_pc", pc, 32'h0);
      chk("reset_dinst", dinst, 32'h0);

      step(0, 2'b00, 1, 0, 0, 0);
      step(0, 2'b00, 1, 0, 0, 0);
      chk("seq_pc8", pc, 32'h8);
      chk("seq_dinst4", dinst, 32'h4 ^ 32'hA5A5_A5A5);

      step(0, 2'b00, 0, 0, 0, 0);
      step(0, 2'b11, 0, 0, 0, 32'h900);
      chk("stall_pc", pc, 32'h8);
      chk("stall_cnt2", stall_cnt, 32'd2);

      step(0, 2'b00, 1, 0, 0, 0);
      step(0, 2'b00, 1, 0, 0, 0);
      chk("resume_pc10", pc, 32'h10);

      step(0, 2'b01, 1, 32'h40, 0, 0);
      chk("branch_pc", pc, 32'h40);
      chk("branch_dpc4", dpc4, 32'h14);
`ifdef IF_FLUSH_EN
      chk("branch_flush", dinst, 32'h0);
`else
      chk("branch_delay_slot", dinst, 32'h10 ^ 32'hA5A5_A5A5);
`endif

      step(0, 2'b00, 1, 0, 0, 0);
      step(0, 2'b10, 1, 0, 32'h1237, 0);
      chk("jr_mask", pc, 32'h1234);
      step(0, 2'b11, 1, 0, 0, 32'h300);
      chk("jump_pc", pc, 32'h300);
      step(0, 2'b11, 1, 0, 0, 32'hFFFF_FFFC);
      step(0, 2'b00, 1, 0, 0, 0);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_dpc4", dpc4, 32'h0);

      for (int i = 0; i < 20; i++) step(0, 2'b00, 0, 0, 0, 0);
      chk("sat_cnt4", {28'h0, stall_cnt_s}, 32'hF);
      chk("cnt32_22", stall_cnt, 32'd22);

      step(0, 2'b01, 1, 32'h80, 0, 0);
      step(0, 2'b01, 0, 32'h200, 0, 0);
      step(1, 2'b01, 0, 32'h200, 0, 0);
      chk("reset_stall_pc", pc, 32'h0);
      chk("reset_stall_cnt", stall_cnt, 32'h0);
      step(0, 2'b00, 1, 0, 0, 0);
      step(0, 2'b00, 1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
